sm3_round_ctrl: RTL and testbench

Sequencer for the SM3 compression function. Steps one 512-bit message block through the 64 rounds and drives the round index `j` shared by the FF/GG boolean-function blocks and the message-expansion unit. Issues load, round, and final-XOR enables to the datapath, and optionally generates the rotated round constant T_j. Sits between the message-block front end (valid/ready handshake) and the compression datapath.

---
 rtl/sm3_pkg.sv | 23 ++
 rtl/sm3_round_ctrl_if.sv | 37 +++
 rtl/sm3_tj_gen.sv | 21 ++
 rtl/sm3_round_ctrl.sv | 88 ++++++++
 tb/tb_sm3_round_ctrl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/sm3_pkg.sv
// Shared SM3 definitions: controller state encoding, round constants and a
// 32-bit rotate helper used by the T_j generator.
package sm3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } sm3_ctrl_state_t;

  localparam logic [31:0] SM3_T0_15  = 32'h79CC4519;
  localparam logic [31:0] SM3_T16_63 = 32'h7A879D8A;
  localparam int          SM3_ROUNDS = 64;

  function automatic logic [31:0] sm3_rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] dbl;
    dbl = {x, x} << n;
    return dbl[63:32];
  endfunction

endpackage

// File: rtl/sm3_round_ctrl_if.sv
// Front-end / datapath control bundle of the SM3 round sequencer.
// output_Tj exists only when SM3_ROUND_CTRL_TJ_EN is defined.
interface sm3_round_ctrl_if;

  logic        input_start;
  logic        input_first;
  logic        input_stall;
  logic        output_ready;
  logic        output_iv_sel;
  logic        output_load_en;
  logic        output_round_en;
  logic [0:5]  output_j;
`ifdef SM3_ROUND_CTRL_TJ_EN
  logic [0:31] output_Tj;
`endif
  logic        output_final_en;
  logic        output_done;

  modport slave (
`ifdef SM3_ROUND_CTRL_TJ_EN
    output output_Tj,
`endif
    input  input_start, input_first, input_stall,
    output output_ready, output_iv_sel, output_load_en, output_round_en,
    output output_j, output_final_en, output_done
  );

  modport master (
`ifdef SM3_ROUND_CTRL_TJ_EN
    input  output_Tj,
`endif
    output input_start, input_first, input_stall,
    input  output_ready, output_iv_sel, output_load_en, output_round_en,
    input  output_j, output_final_en, output_done
  );

endinterface

// File: rtl/sm3_tj_gen.sv
// Round constant T_j rotated left by (j mod 32); purely combinational from j.
module sm3_tj_gen
  import sm3_pkg::*;
(
  input  logic [5:0]  j,
  output logic [31:0] tj
);

  logic [31:0] t_s;

  // constant select by round range, then rotate
  always_comb begin
    if (j <= 6'd15) begin
      t_s = SM3_T0_15;
    end else begin
      t_s = SM3_T16_63;
    end
    tj = sm3_rotl32(t_s, j[4:0]);
  end

endmodule

// File: rtl/sm3_round_ctrl.sv
// SM3 compression sequencer: IDLE -> LOAD -> ROUND x ROUNDS -> FINAL -> DONE.
// Optional T_j output under macro SM3_ROUND_CTRL_TJ_EN.
module sm3_round_ctrl
  import sm3_pkg::*;
#(
  parameter int ROUNDS = SM3_ROUNDS
) (
  input  logic                 input_clk,
  input  logic                 input_rst_n,
  sm3_round_ctrl_if.slave      ctrl
);

  localparam logic [5:0] J_LAST = 6'(ROUNDS - 1);

  sm3_ctrl_state_t state_r, state_nx_s;
  logic [5:0]      j_r, j_nx_s;
  logic            iv_sel_r, iv_sel_nx_s;
  logic            round_en_s;

  // state, round index and IV select registers
  always_ff @(posedge input_clk or negedge input_rst_n) begin
    if (!input_rst_n) begin
      state_r  <= ST_IDLE;
      j_r      <= 6'd0;
      iv_sel_r <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      j_r      <= j_nx_s;
      iv_sel_r <= iv_sel_nx_s;
    end
  end

  // next-state, round index update and round enable
  always_comb begin
    state_nx_s  = state_r;
    j_nx_s      = j_r;
    iv_sel_nx_s = iv_sel_r;
    round_en_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (ctrl.input_start) begin
          state_nx_s  = ST_LOAD;
          j_nx_s      = 6'd0;
          iv_sel_nx_s = ctrl.input_first;
        end else begin
          state_nx_s  = ST_IDLE;
        end
      end
      ST_LOAD: state_nx_s = ST_ROUND;
      ST_ROUND: begin
        round_en_s = ~ctrl.input_stall;
        // exit on the last executed round so j never moves past ROUNDS-1
        if (round_en_s) begin
          if (j_r == J_LAST) begin
            state_nx_s = ST_FINAL;
          end else begin
            j_nx_s = j_r + 6'd1;
          end
        end else begin
          state_nx_s = ST_ROUND;
        end
      end
      ST_FINAL: state_nx_s = ST_DONE;
      ST_DONE:  state_nx_s = ST_IDLE;
      default:  state_nx_s = ST_IDLE;
    endcase
  end

  assign ctrl.output_ready     = (state_r == ST_IDLE);
  assign ctrl.output_load_en   = (state_r == ST_LOAD);
  assign ctrl.output_round_en  = round_en_s;
  assign ctrl.output_final_en  = (state_r == ST_FINAL);
  assign ctrl.output_done      = (state_r == ST_DONE);
  assign ctrl.output_iv_sel    = iv_sel_r;
  assign ctrl.output_j         = j_r;

`ifdef SM3_ROUND_CTRL_TJ_EN
  logic [31:0] tj_s;

  sm3_tj_gen u_tj_gen (
    .j  (j_r),
    .tj (tj_s)
  );

  assign ctrl.output_Tj = tj_s;
`endif

endmodule

// File: tb/tb_sm3_round_ctrl.sv
// Scoreboard bench for sm3_round_ctrl: expected block results are queued at
// stimulus time and retired when done pulses.
`timescale 1ns/1ps
module tb_sm3_round_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  sm3_round_ctrl_if ctrl();

  sm3_round_ctrl #(.ROUNDS(64)) dut (
    .input_clk   (clk),
    .input_rst_n (rst_n),
    .ctrl        (ctrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit iv;
    int lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   ec       = 0;
  int   acc_edge = 0;
  int   acc_cnt  = 0;
  int   done_cnt = 0;
  int   exp_j    = 0;
  int   rnd_cnt  = 0;
  bit   in_blk   = 1'b0;
  bit   cur_iv   = 1'b0;
  bit   prev_fin = 1'b0;
  bit   cont_mode = 1'b0;
  bit   cont_prev = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tj_model(input int jj);
    logic [31:0] t;
    t = (jj < 16) ? 32'h79CC4519 : 32'h7A879D8A;
    for (int i = 0; i < jj % 32; i++) t = {t[30:0], t[31]};
    return t;
  endfunction

  always @(posedge clk) ec <= ec + 1;

  // monitor: cycle number of the interval that ends at edge ec+1
  initial forever begin
    int   cyc;
    exp_t e;
    @(negedge clk);
    cyc = ec + 1;
    if (!rst_n) begin
      in_blk   = 1'b0;
      prev_fin = 1'b0;
      exp_q.delete();
    end else begin
      check_eq("excl", 32'($countones({ctrl.output_ready, ctrl.output_load_en,
               ctrl.output_round_en, ctrl.output_final_en, ctrl.output_done}) <= 1), 32'd1);
      if (in_blk && cyc == acc_edge + 1) check_eq("load_en", 32'(ctrl.output_load_en), 32'd1);
      if (in_blk && cyc > acc_edge) check_eq("iv_hold", 32'(ctrl.output_iv_sel), 32'(cur_iv));
      if (ctrl.output_round_en) begin
        check_eq("j_seq", 32'(ctrl.output_j), 32'(exp_j));
`ifdef SM3_ROUND_CTRL_TJ_EN
        check_eq("tj_model", ctrl.output_Tj, tj_model(exp_j));
        case (exp_j)
          0:  check_eq("tj_j0",  ctrl.output_Tj, 32'h79CC4519);
          1:  check_eq("tj_j1",  ctrl.output_Tj, 32'hF3988A32);
          16: check_eq("tj_j16", ctrl.output_Tj, 32'h9D8A7A87);
          33: check_eq("tj_j33", ctrl.output_Tj, 32'hF50F3B14);
          default: ;
        endcase
`endif
        exp_j++;
        rnd_cnt++;
      end
      if (ctrl.output_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check_eq("spurious_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_eq("done_lat", 32'(cyc - acc_edge), 32'(e.lat));
          check_eq("iv_sel", 32'(ctrl.output_iv_sel), 32'(e.iv));
          check_eq("rounds", 32'(rnd_cnt), 32'd64);
          check_eq("final_before_done", 32'(prev_fin), 32'd1);
        end
        in_blk = 1'b0;
      end
      prev_fin = ctrl.output_final_en;
      if (ctrl.output_ready && ctrl.input_start) begin
        if (cont_mode && cont_prev) check_eq("accept_gap", 32'(cyc - acc_edge), 32'd68);
        cont_prev = cont_mode;
        acc_edge  = cyc;
        acc_cnt++;
        in_blk    = 1'b1;
        exp_j     = 0;
        rnd_cnt   = 0;
        cur_iv    = ctrl.input_first;
      end
    end
  end

  task automatic check_reset_vals();
    check_eq("rst_ready",  32'(ctrl.output_ready), 32'd1);
    check_eq("rst_j",      32'(ctrl.output_j), 32'd0);
    check_eq("rst_iv",     32'(ctrl.output_iv_sel), 32'd0);
    check_eq("rst_load",   32'(ctrl.output_load_en), 32'd0);
    check_eq("rst_round",  32'(ctrl.output_round_en), 32'd0);
    check_eq("rst_final",  32'(ctrl.output_final_en), 32'd0);
    check_eq("rst_done",   32'(ctrl.output_done), 32'd0);
`ifdef SM3_ROUND_CTRL_TJ_EN
    check_eq("rst_tj",     ctrl.output_Tj, 32'h79CC4519);
`endif
  endtask

  task automatic start_block(input bit f);
    int a0;
    a0 = acc_cnt;
    @(posedge clk); #1;
    ctrl.input_first = f;
    ctrl.input_start = 1'b1;
    for (int i = 0; i < 20 && acc_cnt == a0; i++) begin
      @(posedge clk); #1;
    end
    ctrl.input_start = 1'b0;
    check_eq("accepted", 32'(acc_cnt - a0), 32'd1);
  endtask

  task automatic run_block(input bit f, input int nstall);
    int d0;
    bit found;
    d0 = done_cnt;
    found = 1'b0;
    exp_q.push_back('{iv: f, lat: 67 + nstall});
    start_block(f);
    if (nstall > 0) begin
      for (int i = 0; i < 100 && !found; i++) begin
        @(posedge clk); #1;
        if (ctrl.output_j == 6'd63 && ctrl.output_round_en) found = 1'b1;
      end
      check_eq("reach_j63", 32'(found), 32'd1);
      ctrl.input_stall = 1'b1;
      for (int i = 0; i < nstall; i++) begin
        #1;
        check_eq("stall_j", 32'(ctrl.output_j), 32'd63);
        check_eq("stall_round_en", 32'(ctrl.output_round_en), 32'd0);
        @(posedge clk); #1;
      end
      ctrl.input_stall = 1'b0;
    end
    for (int i = 0; i < 300 && done_cnt == d0; i++) begin
      @(posedge clk); #1;
    end
    check_eq("done_seen", 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int  a0;
    int  d0;
    bit  found;
    ctrl.input_start = 1'b0;
    ctrl.input_first = 1'b0;
    ctrl.input_stall = 1'b0;
    #2 rst_n = 1'b0;
    #2 check_reset_vals();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_block(1'b1, 0);
    run_block(1'b0, 0);
    run_block(1'b1, 0);
    run_block(1'b0, 5);

    // start held high across two blocks
    exp_q.push_back('{iv: 1'b0, lat: 67});
    exp_q.push_back('{iv: 1'b0, lat: 67});
    a0 = acc_cnt;
    d0 = done_cnt;
    @(posedge clk); #1;
    cont_mode = 1'b1;
    ctrl.input_first = 1'b0;
    ctrl.input_start = 1'b1;
    for (int i = 0; i < 400 && acc_cnt < a0 + 2; i++) begin
      @(posedge clk); #1;
    end
    ctrl.input_start = 1'b0;
    for (int i = 0; i < 200 && done_cnt < d0 + 2; i++) begin
      @(posedge clk); #1;
    end
    cont_mode = 1'b0;
    check_eq("cont_accepts", 32'(acc_cnt - a0), 32'd2);
    check_eq("cont_dones", 32'(done_cnt - d0), 32'd2);

    // reset in the middle of a block
    exp_q.push_back('{iv: 1'b1, lat: 67});
    d0 = done_cnt;
    found = 1'b0;
    start_block(1'b1);
    for (int i = 0; i < 100 && !found; i++) begin
      @(posedge clk); #1;
      if (ctrl.output_j == 6'd30 && ctrl.output_round_en) found = 1'b1;
    end
    check_eq("reach_j30", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #1 check_reset_vals();
    @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (80) @(posedge clk);
    #1 check_eq("no_done_after_rst", 32'(done_cnt - d0), 32'd0);
    run_block(1'b1, 0);

    repeat (3) @(posedge clk);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
